serial_deser: RTL and testbench

- Downstream consumer of the 8-bit load/shift register's serial output (cout).
- Collects WIDTH serial bits into a parallel word, honouring the same dir convention as the shifter: 0 = MSB first, 1 = LSB first.
- Presents each completed word through a one-entry valid/ready output buffer, with sticky overrun detection.
- Sits between the shifter and any byte-wide consumer, such as a display or FIFO.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_deser_shreg.sv | 69 ++++++
 rtl/serial_deser.sv | 104 ++++++++++
 tb/tb_serial_deser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants and types for the serial deserializer.
// Optional parity build: define SERIAL_DESER_PARITY_EN.
package serial_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

`ifdef SERIAL_DESER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/serial_deser_shreg.sv
// WIDTH-bit deserializing shift register plus bit counter; word shows the
// next-state contents so the top can capture it on the completing edge.
module deser_shreg
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    input  logic             dir,
    output logic [WIDTH-1:0] word,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH + PAR_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done    = 1'b0;
        if (sin_en) begin
            if (start) begin
                dir_d   = dir;
                cnt_d   = CNT_W'(1);
                shift_d = (dir == DIR_LSB_FIRST) ? {sin, {(WIDTH-1){1'b0}}}
                                                 : {{(WIDTH-1){1'b0}}, sin};
            end else if (cnt_q != '0) begin
                // The trailing parity bit (if any) is counted but never shifted in.
                if (cnt_q < DATA_END) begin
                    shift_d = (dir_q == DIR_LSB_FIRST) ? {sin, shift_q[WIDTH-1:1]}
                                                       : {shift_q[WIDTH-2:0], sin};
                end
                if (cnt_q == LAST) begin
                    done  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign word = shift_d;

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel deserializer with one-entry valid/ready output buffer
// and sticky overrun. Optional parity check enabled by SERIAL_DESER_PARITY_EN.
module serial_deser
    import serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame,
    input  logic             dir,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             busy,
    output logic             parity_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word;
    logic             done;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;
    logic             load_word;

    deser_shreg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .sin    (sin),
        .sin_en (sin_en),
        .start  (frame),
        .dir    (dir),
        .word   (word),
        .done   (done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sin_en && frame) state_d = SHIFT;
            SHIFT:   if (done)            state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
    end

    // A full buffer being popped this cycle can take the new word losslessly.
    assign load_word = done && (!dout_valid_q || dout_ready);

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (load_word) begin
            dout_d       = word;
            dout_valid_d = 1'b1;
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
        overrun_d = (done && dout_valid_q && !dout_ready) || (overrun_q && !ovr_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

`ifdef SERIAL_DESER_PARITY_EN
    // On the parity edge word holds the data bits and sin is the parity bit.
    logic parity_err_q;
    always_ff @(posedge clk) begin
        if (rst)            parity_err_q <= 1'b0;
        else if (load_word) parity_err_q <= (^word) ^ sin;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deser.sv
// Scoreboard bench for serial_deser: stimulus pushes expected words, a
// negedge monitor pops and compares on every accepted output.
module tb_serial_deser;

    localparam int W = 8;
`ifdef SERIAL_DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         p;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, sin, sin_en, frame, dir, dout_ready, ovr_clr;
    logic [W-1:0] dout;
    logic         dout_valid, overrun, busy, parity_err;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_deser dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_en     (sin_en),
        .frame      (frame),
        .dir        (dir),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .busy       (busy),
        .parity_err (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_perr(input logic [W-1:0] d, input logic p);
        return (PAR == 1) ? ((^d) ^ p) : 1'b0;
    endfunction

    task automatic drive_bit(input logic b, input logic frm, input logic d);
        @(posedge clk); #1;
        sin = b; sin_en = 1'b1; frame = frm; dir = d;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        sin = 1'b0; sin_en = 1'b0; frame = 1'b0;
    endtask

    // Sends one word; gap inserts an idle cycle (sin_en=0) after every bit.
    task automatic send_word(input logic [W-1:0] data, input logic d, input logic p,
                             input bit accept, input bit gap);
        exp_t e;
        if (accept) begin
            e.d = data;
            e.p = exp_perr(data, p);
            sb.push_back(e);
        end
        for (int i = 0; i < W; i++) begin
            drive_bit(d ? data[i] : data[W-1-i], (i == 0), d);
            if (gap) idle();
        end
        if (PAR == 1) drive_bit(p, 1'b0, d);
    endtask

    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none at %0t", dout, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_dout", dout, e.d);
                check("sb_parity_err", parity_err, e.p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0; frame = 1'b0; dir = 1'b0;
        dout_ready = 1'b0; ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Unframed bits in IDLE are ignored.
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        idle();
        check("idle_ignore_busy", busy, 0);

        // MSB-first 0x55; valid exactly one cycle.
        dout_ready = 1'b1;
        send_word(8'h55, 1'b0, 1'b0, 1, 0);
        check("msb_busy_last", busy, 1);
        idle();
        check("msb_valid", dout_valid, 1);
        check("msb_busy_done", busy, 0);
        idle();
        check("msb_valid_drop", dout_valid, 0);

        // LSB-first 0xAA.
        send_word(8'hAA, 1'b1, 1'b0, 1, 0);
        idle();
        idle();

        // Backpressure, drop with overrun (set dominates clear), sticky, clear.
        dout_ready = 1'b0;
        send_word(8'h55, 1'b0, 1'b0, 1, 0);
        idle();
        check("bp_valid", dout_valid, 1);
        check("bp_dout", dout, 8'h55);
        ovr_clr = 1'b1;
        send_word(8'hFF, 1'b0, 1'b0, 0, 0);
        idle();
        ovr_clr = 1'b0;
        check("ovr_set_dominates", overrun, 1);
        check("ovr_dout_kept", dout, 8'h55);
        idle();
        check("ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        idle();
        ovr_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("bp_valid_held", dout_valid, 1);
        dout_ready = 1'b1;
        idle();
        check("bp_popped", dout_valid, 0);

        // Back-to-back words with no dead cycle.
        send_word(8'h12, 1'b0, 1'b0, 1, 0);
        send_word(8'hC3, 1'b1, 1'b1, 1, 0);
        idle();
        idle();

        // sin_en gaps hold state.
        send_word(8'hA5, 1'b0, 1'b0, 1, 1);
        idle();
        idle();

        // Re-sync: three bits of a partial word, then a framed 0x3C.
        drive_bit(1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b0, 1'b1);
        drive_bit(1'b0, 1'b0, 1'b1);
        send_word(8'h3C, 1'b0, 1'b0, 1, 0);
        idle();
        idle();

        // Parity bit correct, then wrong (flag only meaningful in parity build).
        send_word(8'h55, 1'b0, 1'b0, 1, 0);
        idle();
        idle();
        send_word(8'h55, 1'b0, 1'b1, 1, 0);
        idle();
        idle();

        // Mid-word reset discards the partial word.
        for (int i = 0; i < 4; i++) drive_bit(1'b1, (i == 0), 1'b0);
        @(posedge clk); #1;
        sin_en = 1'b0; frame = 1'b0;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", dout_valid, 0);
        idle();
        check("mid_rst_no_word", dout_valid, 0);

        // Recovery after reset.
        send_word(8'h81, 1'b1, 1'b0, 1, 0);
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) idle();
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
